// File: rtl/seq_add32_pkg.sv
// Shared ALU definitions for the byte-serial adder.
//   state_e   : sequencer state encoding (IDLE/BUSY/DONE)
//   SliceW    : width of the reused adder slice
//   alu_op_e  : add/subtract op-code
package seq_add32_pkg;

  localparam int unsigned SliceW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } alu_op_e;

endpackage

// File: rtl/add8.sv
// 8-bit carry-lookahead adder slice.
// Ports:
//   a, b  : 8-bit operands
//   c_1   : carry into bit 0
//   s     : 8-bit sum
//   c7    : carry out of bit 7
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_1,
  output logic [7:0] s,
  output logic       c7
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       acc;
  logic       prod;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat sum-of-products over all lower generate/propagate terms,
  // so no carry depends on another carry.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = c_1;
    for (int i = 0; i < 8; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      acc      = acc | (prod & c_1);
      c[i + 1] = acc;
    end
  end

  assign s  = p ^ c[7:0];
  assign c7 = c[8];

endmodule

// File: rtl/seq_add32.sv
// Multi-cycle WIDTH-bit add/subtract unit. One 8-bit CLA slice is reused once per
// byte, least-significant byte first, with the carry registered between cycles.
// Build option: define SEQ_ADD_FLAGS_EN to add registered zero/negative/overflow flags.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake
//   in_a, in_b, in_sub    : operands and op select (1 = A-B)
//   out_valid/out_ready   : result handshake
//   out_sum, out_cout     : result and raw carry out (subtract: 1 = no borrow)
//   out_zero/neg/ovf      : result flags (SEQ_ADD_FLAGS_EN only)
module seq_add32
  import seq_add32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef SEQ_ADD_FLAGS_EN
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int unsigned NB = WIDTH / SliceW;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  if ((WIDTH % SliceW) != 0 || WIDTH < SliceW) begin : g_bad_width
    $error("seq_add32: WIDTH must be a multiple of 8 and at least 8");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [CW-1:0]     k_q, k_d;

  alu_op_e           op;
  logic [WIDTH-1:0]  a_shift;
  logic [WIDTH-1:0]  b_shift;
  logic [SliceW-1:0] slice_a;
  logic [SliceW-1:0] slice_b;
  logic [SliceW-1:0] slice_s;
  logic              slice_c;
  logic              last_byte;

  assign op = alu_op_e'(in_sub);

  // Current byte of each operand lands in the low slice of the shifted value.
  assign a_shift   = op_a_q >> (32'(k_q) * SliceW);
  assign b_shift   = op_b_q >> (32'(k_q) * SliceW);
  assign slice_a   = a_shift[SliceW-1:0];
  assign slice_b   = b_shift[SliceW-1:0];
  assign last_byte = (k_q == CW'(NB - 1));

  add8 u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .c_1 (carry_q),
    .s   (slice_s),
    .c7  (slice_c)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = in_a;
          // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
          op_b_d  = (op == OpSub) ? ~in_b : in_b;
          carry_d = (op == OpSub);
          k_d     = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (k_q == CW'(i)) begin
            sum_d[i*SliceW +: SliceW] = slice_s;
          end
        end
        carry_d = slice_c;
        if (last_byte) begin
          cout_d  = slice_c;
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

`ifdef SEQ_ADD_FLAGS_EN
  logic zero_q, neg_q, ovf_q;
  logic flag_load;

  // Flags are captured from the fully assembled sum on the final byte edge.
  assign flag_load = (state_q == StBusy) && last_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (flag_load) begin
      zero_q <= (sum_d == '0);
      neg_q  <= sum_d[WIDTH-1];
      ovf_q  <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (sum_d[WIDTH-1] != op_a_q[WIDTH-1]);
    end
  end

  assign out_zero = zero_q;
  assign out_neg  = neg_q;
  assign out_ovf  = ovf_q;
`else
  // Flag ports and their registers are not built.
`endif

endmodule

// File: doc/seq_add32.md
Name: seq_add32

Overview:
- Multi-cycle WIDTH-bit add/subtract unit for the ALU path; an area-saving alternative to a full-width CLA.
- Reuses one 8-bit CLA slice once per byte, least-significant byte first, and registers the carry between cycles.
- Sits between operand selection (upstream) and ALU result mux / writeback (downstream).
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8 and at least 8; NB = WIDTH/8 byte steps.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = compute A-B, 0 = compute A+B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result, modulo 2^WIDTH
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- out_zero  out  1  result == 0 (SEQ_ADD_FLAGS_EN only)
- out_neg  out  1  result MSB (SEQ_ADD_FLAGS_EN only)
- out_ovf  out  1  signed overflow (SEQ_ADD_FLAGS_EN only)

Behaviour:
- Reset: all output registers, state and internal registers are cleared whenever rst_n=0 at a rising edge of clk.
  - After reset: state = IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, all flags 0.
- Reset mid-operation aborts the in-flight operation; its result is never presented.
- FSM has three states:
  - IDLE: in_ready=1.
    - On in_valid & in_ready: latch opA=in_a and opB = in_sub ? ~in_b : in_b; set carry register = in_sub; byte index k=0; go to BUSY.
  - BUSY: in_ready=0, out_valid=0.
    - Each cycle: slice computes opA[8k+7:8k] + opB[8k+7:8k] + carry.
    - Write the byte into sum[8k+7:8k], carry <= slice carry-out, k <= k+1.
    - After byte NB-1: go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - out_sum, out_cout and flags are stable until out_ready=1.
    - On out_valid & out_ready: go to IDLE. The next operand is accepted no earlier than the following cycle.
- Latency and throughput:
  - An operand accepted on edge T gives out_valid=1 after edge T+NB (4 cycles for WIDTH=32).
  - Throughput is one operation per NB+2 cycles when out_ready is held high.
- Inputs in_a, in_b and in_sub are sampled only on the accept edge; later changes are ignored.
- out_ready=0 in DONE holds the result indefinitely (backpressure).
- in_valid outside IDLE is ignored and is not queued.
- Arithmetic wraps modulo 2^WIDTH.
- out_cout is the raw final carry: subtract gives cout=1 when A >= B unsigned.
- The byte counter is $clog2(NB) bits wide (minimum 1) and must not wrap inside an operation.

Optional Feature:
- Macro SEQ_ADD_FLAGS_EN.
- Defined:
  - out_zero = (out_sum==0).
  - out_neg = out_sum[WIDTH-1].
  - out_ovf = (opA[MSB]==opB[MSB]) & (out_sum[MSB]!=opA[MSB]), where opB is the post-inversion operand.
  - Flags are registered, update on the same edge as out_sum, and reset to 0.
- Undefined: the three flag ports and their logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared ALU package holds:
  - state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - a constant for the slice width (8);
  - the ALU op-code for add/sub selection.
- One sub-module: the existing 8-bit CLA slice add8 (ports a, b, c_1, s, c7), instantiated once.
- All sequencing and registers stay in seq_add32.

Test Plan (WIDTH=32):
- Basic add:
  - Stimulus: A=0x0000_00FF, B=0x0000_0001, add, out_ready=1.
  - Response: out_valid 4 cycles after accept; sum=0x0000_0100; cout=0.
- Full carry chain:
  - Stimulus: A=0xFFFF_FFFF, B=0x0000_0001, add.
  - Response: sum=0x0000_0000, cout=1; with flags enabled, zero=1, ovf=0.
- Subtract:
  - Stimulus: A=5, B=7, sub.
  - Response: sum=0xFFFF_FFFE, cout=0, neg=1.
  - Also: A=7, B=5 gives sum=2, cout=1.
- Signed overflow:
  - Stimulus: A=0x7FFF_FFFF, B=1, add.
  - Response: sum=0x8000_0000, ovf=1, neg=1, cout=0.
- Backpressure and ignored input:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE, while in_valid=1 with other operands.
  - Response: result held stable, in_ready=0, the new operands are not accepted.
  - Release out_ready: IDLE follows, then the new operands are accepted.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during BUSY cycle 2.
  - Response: next edge gives IDLE, out_valid=0, out_sum=0, in_ready=1; no stale result ever appears.
